// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: immediate-extension stage followed by a circular output buffer.
// Each accepted immediate is transformed according to in_mode at push time and
// the OUT_W-bit result is queued; results leave strictly in push order.
//
// Optional feature: define IMM_EXTEND_MODE_STATS_EN to add the mode_hits output,
// four saturating 16-bit push counters (one per mode, mode 3 in the MSBs).
//
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
// in_ready depends only on occupancy (never on out_ready), and out_valid only on
// occupancy, so there is no combinational path from the input side to the output.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_imm,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OUT_W-1:0]         out_data,
`ifdef IMM_EXTEND_MODE_STATS_EN
    output logic [63:0]              mode_hits,
`endif
    output logic [$clog2(DEPTH):0]   out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] result;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_count = count;
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Extension transform, evaluated on the incoming immediate
    always_comb begin
        sext = {{(OUT_W-IN_W){in_imm[IN_W-1]}}, in_imm};
        zext = {{(OUT_W-IN_W){1'b0}}, in_imm};
        case (in_mode)
            2'b00:   result = sext;
            2'b01:   result = zext;
            2'b10:   result = zext << IN_W;
            default: result = sext << 2;
        endcase
    end

    // Buffer storage: written on push only, contents are not reset
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= result;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef IMM_EXTEND_MODE_STATS_EN
    logic [15:0] hits [4];

    // Per-mode push counters, saturating at all ones
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int m = 0; m < 4; m++) begin
                hits[m] <= '0;
            end
        end else begin
            for (int m = 0; m < 4; m++) begin
                if (push && (in_mode == 2'(m)) && (hits[m] != 16'hFFFF)) begin
                    hits[m] <= hits[m] + 16'd1;
                end
            end
        end
    end

    assign mode_hits = {hits[3], hits[2], hits[1], hits[0]};
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed testbench for imm_extend_pipe at default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_imm_extend_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_count;
`ifdef IMM_EXTEND_MODE_STATS_EN
    logic [63:0] mode_hits;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef IMM_EXTEND_MODE_STATS_EN
        .mode_hits (mode_hits),
`endif
        .out_count (out_count)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [15:0] imm, input logic [1:0] mode);
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin $display("FAIL reset_out_valid got %b want 0", out_valid); n_fail++; end
        n_tests++;
        if (in_ready !== 1'b1) begin $display("FAIL reset_in_ready got %b want 1", in_ready); n_fail++; end
        n_tests++;
        if (out_count !== 3'd0) begin $display("FAIL reset_count got %0d want 0", out_count); n_fail++; end
        reset = 1'b0;
    endtask

    task automatic test_sign_extend();
        logic [15:0] imms [3] = '{16'hFFFF, 16'h8000, 16'h7FFF};
        logic [31:0] exps [3] = '{32'hFFFFFFFF, 32'hFFFF8000, 32'h00007FFF};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_push(imms[i], 2'b00);
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exps[i] || out_count !== 3'd1) begin
                $display("FAIL sext_%0d got v=%b d=%h c=%0d want v=1 d=%h c=1", i, out_valid, out_data, out_count, exps[i]);
                n_fail++;
            end
        end
        in_valid = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin $display("FAIL sext_drain got v=%b want 0", out_valid); n_fail++; end
    endtask

    task automatic test_modes();
        logic [1:0]  modes [3] = '{2'b01, 2'b10, 2'b11};
        logic [31:0] exps [3] = '{32'h00008001, 32'h80010000, 32'hFFFE0004};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_push(16'h8001, modes[i]);
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exps[i]) begin
                $display("FAIL mode_%0d got v=%b d=%h want v=1 d=%h", modes[i], out_valid, out_data, exps[i]);
                n_fail++;
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_fill_drain();
        logic [15:0] imms [5] = '{16'h8001, 16'h1234, 16'hABCD, 16'h0003, 16'h5555};
        logic [1:0]  modes [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        logic [31:0] exps [4] = '{32'hFFFF8001, 32'h00001234, 32'hABCD0000, 32'h0000000C};
        out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            drive_push(imms[i], modes[i]);
            step();
            exp_q.push_back(exps[i]);
        end
        n_tests++;
        if (in_ready !== 1'b0 || out_count !== 3'd4) begin
            $display("FAIL full_flags got rdy=%b c=%0d want rdy=0 c=4", in_ready, out_count); n_fail++;
        end
        drive_push(imms[4], modes[4]);
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_count !== 3'd4 || in_ready !== 1'b0) begin
            $display("FAIL full_drop got c=%0d rdy=%b want c=4 rdy=0", out_count, in_ready); n_fail++;
        end
        n_tests++;
        if (out_data !== 32'hFFFF8001) begin
            $display("FAIL hold_stable got %h want ffff8001", out_data); n_fail++;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                $display("FAIL drain_%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_q[0]); n_fail++;
            end
            void'(exp_q.pop_front());
            step();
        end
        n_tests++;
        if (out_valid !== 1'b0 || out_count !== 3'd0 || in_ready !== 1'b1) begin
            $display("FAIL drain_empty got v=%b c=%0d rdy=%b want v=0 c=0 rdy=1", out_valid, out_count, in_ready); n_fail++;
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            drive_push(16'h0100 + 16'(i), 2'b01);
            step();
            exp_q.push_back(32'h00000100 + 32'(i));
        end
        out_ready = 1'b1;
        for (int i = 2; i < 8; i++) begin
            drive_push(16'h0100 + 16'(i), 2'b01);
            n_tests++;
            if (out_data !== exp_q[0]) begin
                $display("FAIL b2b_order_%0d got %h want %h", i, out_data, exp_q[0]); n_fail++;
            end
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(32'h00000100 + 32'(i));
            n_tests++;
            if (out_count !== 3'd2) begin
                $display("FAIL b2b_count_%0d got %0d want 2", i, out_count); n_fail++;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                $display("FAIL b2b_tail_%0d got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp_q[0]); n_fail++;
            end
            void'(exp_q.pop_front());
            step();
        end
        n_tests++;
        if (out_valid !== 1'b0) begin $display("FAIL b2b_empty got v=%b want 0", out_valid); n_fail++; end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_push(16'hAAA0 + 16'(i), 2'b01);
            step();
        end
        n_tests++;
        if (out_count !== 3'd3) begin $display("FAIL pre_reset_count got %0d want 3", out_count); n_fail++; end
        reset = 1'b1;
        drive_push(16'hBEEF, 2'b01);
        step();
        reset = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || out_count !== 3'd0 || in_ready !== 1'b1) begin
            $display("FAIL mid_reset got v=%b c=%0d rdy=%b want v=0 c=0 rdy=1", out_valid, out_count, in_ready); n_fail++;
        end
        out_ready = 1'b1;
        step();
        step();
        n_tests++;
        if (out_valid !== 1'b0 || out_count !== 3'd0) begin
            $display("FAIL empty_pop got v=%b c=%0d want v=0 c=0", out_valid, out_count); n_fail++;
        end
        drive_push(16'h0042, 2'b00);
        step();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h00000042) begin
            $display("FAIL post_reset got v=%b d=%h want v=1 d=00000042", out_valid, out_data); n_fail++;
        end
        step();
    endtask

`ifdef IMM_EXTEND_MODE_STATS_EN
    task automatic test_mode_stats();
        reset = 1'b1;
        in_valid = 1'b0;
        step();
        reset = 1'b0;
        n_tests++;
        if (mode_hits !== 64'h0) begin $display("FAIL stats_reset got %h want 0", mode_hits); n_fail++; end
        out_ready = 1'b1;
        drive_push(16'h0001, 2'b00);
        for (int i = 0; i < 70000; i++) begin
            step();
        end
        in_valid = 1'b0;
        n_tests++;
        if (mode_hits !== 64'h0000_0000_0000_FFFF) begin
            $display("FAIL stats_saturate got %h want 000000000000ffff", mode_hits); n_fail++;
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_sign_extend();
        test_modes();
        test_fill_drain();
        test_back_to_back();
        test_reset_mid();
`ifdef IMM_EXTEND_MODE_STATS_EN
        test_mode_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
